// File: rtl/parking_occupancy_counter_if.sv
// Sensor inputs and occupancy/gate outputs of the parking occupancy counter.
interface parking_occupancy_counter_if #(
  parameter int CNT_W = 5
);
  logic             entry_sensor;
  logic             exit_sensor;
  logic             next_full;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free_slots;
  logic             entry_gate_open;
  logic             exit_gate_open;
  logic             entry_reject;
  logic             exit_error;

  modport master (
    output entry_sensor, exit_sensor,
    input  next_full, count, free_slots, entry_gate_open, exit_gate_open,
           entry_reject, exit_error
  );

  modport slave (
    input  entry_sensor, exit_sensor,
    output next_full, count, free_slots, entry_gate_open, exit_gate_open,
           entry_reject, exit_error
  );
endinterface

// File: rtl/parking_occupancy_counter.sv
// Parking lot occupancy counter: debounced entry/exit lanes, saturating count, gate control.
// Optional macro GATE_HOLD_EN keeps each gate open GATE_HOLD_CYCLES after its lane releases.
module parking_occupancy_counter #(
  parameter int CAPACITY         = 16,
  parameter int CNT_W            = 5,
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int GATE_HOLD_CYCLES = 1000000
) (
  input logic                       clk,
  input logic                       rst_n,
  parking_occupancy_counter_if.slave bus
);
  typedef enum logic [1:0] {S_LOW, S_PH, S_HIGH, S_PL} lane_state_e;

  localparam int             DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

  logic [1:0]       raw_s;
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       event_s;
  logic [1:0]       to_low_s;
  logic [1:0]       accept_s;
  logic [1:0]       gate_s;
  logic             reject_s;
  logic             error_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] free_r;
  logic             full_r;
  logic             reject_r;
  logic             error_r;

  // Lane 0 is entry, lane 1 is exit.
  assign raw_s = {bus.exit_sensor, bus.entry_sensor};

  // Two-flop synchronisers for the asynchronous sensor inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_lane
    lane_state_e     state_r;
    lane_state_e     state_nxt_s;
    logic [DB_W-1:0] timer_r;
    logic [DB_W-1:0] timer_nxt_s;
    logic            done_s;
    logic            gate_r;

    assign done_s      = (timer_r == DB_MAX);
    assign event_s[g]  = (state_r == S_PH) && sync2_r[g] && done_s;
    assign to_low_s[g] = (state_r == S_PL) && !sync2_r[g] && done_s;
    assign gate_s[g]   = gate_r;

    // Debounce state and stability timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r <= S_LOW;
        timer_r <= {DB_W{1'b0}};
      end else begin
        state_r <= state_nxt_s;
        timer_r <= timer_nxt_s;
      end
    end

    // Debounce next-state: a level is accepted only after it has been stable long enough.
    always_comb begin
      state_nxt_s = state_r;
      timer_nxt_s = {DB_W{1'b0}};
      case (state_r)
        S_LOW: begin
          if (sync2_r[g]) begin
            state_nxt_s = S_PH;
          end else begin
            state_nxt_s = S_LOW;
          end
        end
        S_PH: begin
          if (!sync2_r[g]) begin
            state_nxt_s = S_LOW;
          end else if (done_s) begin
            state_nxt_s = S_HIGH;
          end else begin
            timer_nxt_s = timer_r + DB_W'(1);
          end
        end
        S_HIGH: begin
          if (!sync2_r[g]) begin
            state_nxt_s = S_PL;
          end else begin
            state_nxt_s = S_HIGH;
          end
        end
        S_PL: begin
          if (sync2_r[g]) begin
            state_nxt_s = S_HIGH;
          end else if (done_s) begin
            state_nxt_s = S_LOW;
          end else begin
            timer_nxt_s = timer_r + DB_W'(1);
          end
        end
        default: begin
          state_nxt_s = S_LOW;
        end
      endcase
    end

`ifdef GATE_HOLD_EN
    localparam int HOLD_W = $clog2(GATE_HOLD_CYCLES + 1);
    logic [HOLD_W-1:0] hold_r;

    // Gate opens on an accepted car; closes once the hold timer runs out after release.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gate_r <= 1'b0;
        hold_r <= {HOLD_W{1'b0}};
      end else if (accept_s[g]) begin
        gate_r <= 1'b1;
        hold_r <= {HOLD_W{1'b0}};
      end else if (to_low_s[g] && gate_r) begin
        gate_r <= (GATE_HOLD_CYCLES != 0);
        hold_r <= HOLD_W'(GATE_HOLD_CYCLES);
      end else if (hold_r != {HOLD_W{1'b0}}) begin
        gate_r <= (hold_r != HOLD_W'(1));
        hold_r <= hold_r - HOLD_W'(1);
      end else begin
        gate_r <= gate_r;
        hold_r <= hold_r;
      end
    end
`else
    // Gate opens on an accepted car and closes as the lane returns to idle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gate_r <= 1'b0;
      end else if (accept_s[g]) begin
        gate_r <= 1'b1;
      end else if (to_low_s[g]) begin
        gate_r <= 1'b0;
      end else begin
        gate_r <= gate_r;
      end
    end
`endif
  end

`ifndef GATE_HOLD_EN
  logic unused_hold_cfg_s;
  assign unused_hold_cfg_s = (GATE_HOLD_CYCLES != 0);
`endif

  // Occupancy update; simultaneous entry and exit cancel out and are always accepted.
  always_comb begin
    cnt_nxt_s = count_r;
    accept_s  = 2'b00;
    reject_s  = 1'b0;
    error_s   = 1'b0;
    case (event_s)
      2'b11: begin
        accept_s = 2'b11;
      end
      2'b01: begin
        if (count_r < CAP_C) begin
          cnt_nxt_s = count_r + CNT_W'(1);
          accept_s  = 2'b01;
        end else begin
          reject_s = 1'b1;
        end
      end
      2'b10: begin
        if (count_r != {CNT_W{1'b0}}) begin
          cnt_nxt_s = count_r - CNT_W'(1);
          accept_s  = 2'b10;
        end else begin
          error_s = 1'b1;
        end
      end
      default: begin
        cnt_nxt_s = count_r;
      end
    endcase
  end

  // Count, derived flags and pulses are registered together so they never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= {CNT_W{1'b0}};
      free_r   <= CAP_C;
      full_r   <= 1'b0;
      reject_r <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      count_r  <= cnt_nxt_s;
      free_r   <= CAP_C - cnt_nxt_s;
      full_r   <= (cnt_nxt_s == CAP_C);
      reject_r <= reject_s;
      error_r  <= error_s;
    end
  end

  assign bus.count           = count_r;
  assign bus.free_slots      = free_r;
  assign bus.next_full       = full_r;
  assign bus.entry_reject    = reject_r;
  assign bus.exit_error      = error_r;
  assign bus.entry_gate_open = gate_s[0];
  assign bus.exit_gate_open  = gate_s[1];
endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Bench for parking_occupancy_counter: directed scenarios plus random sensor traffic
// compared every cycle against a run-length behavioural model of the lot.
module tb_parking_occupancy_counter;
  localparam int CAP  = 3;
  localparam int CW   = 5;
  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  parking_occupancy_counter_if #(.CNT_W(CW)) bus ();

  parking_occupancy_counter #(
    .CAPACITY(CAP), .CNT_W(CW), .DEBOUNCE_CYCLES(DEB), .GATE_HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a lane's accepted level flips once the synchronised sensor (raw delayed
  // two clocks) has disagreed with it for DEB+1 consecutive samples.
  int m_cnt = 0;
  bit m_lvl  [2];
  int m_run  [2];
  bit m_d1   [2];
  bit m_d2   [2];
  bit m_open [2];
  int m_hold [2];
  bit m_rej = 1'b0;
  bit m_err = 1'b0;
  bit m_up   [2];
  bit m_dn   [2];
  bit m_acc  [2];
  bit m_raw  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_rej = 1'b0; m_err = 1'b0;
      for (int l = 0; l < 2; l++) begin
        m_lvl[l] = 1'b0; m_run[l] = 0; m_d1[l] = 1'b0; m_d2[l] = 1'b0;
        m_open[l] = 1'b0; m_hold[l] = 0;
      end
    end else begin
      m_raw[0] = bus.entry_sensor;
      m_raw[1] = bus.exit_sensor;
      for (int l = 0; l < 2; l++) begin
        bit s;
        s = m_d2[l];
        m_d2[l] = m_d1[l];
        m_d1[l] = m_raw[l];
        m_up[l] = 1'b0; m_dn[l] = 1'b0; m_acc[l] = 1'b0;
        if (s != m_lvl[l]) begin
          m_run[l]++;
          if (m_run[l] == DEB + 1) begin
            m_lvl[l] = s; m_run[l] = 0;
            m_up[l] = s; m_dn[l] = !s;
          end
        end else begin
          m_run[l] = 0;
        end
      end
      m_rej = 1'b0; m_err = 1'b0;
      if (m_up[0] && m_up[1]) begin
        m_acc[0] = 1'b1; m_acc[1] = 1'b1;
      end else if (m_up[0]) begin
        if (m_cnt < CAP) begin m_cnt++; m_acc[0] = 1'b1; end
        else m_rej = 1'b1;
      end else if (m_up[1]) begin
        if (m_cnt > 0) begin m_cnt--; m_acc[1] = 1'b1; end
        else m_err = 1'b1;
      end
      for (int l = 0; l < 2; l++) begin
        if (m_acc[l]) begin
          m_open[l] = 1'b1; m_hold[l] = 0;
        end else if (m_dn[l] && m_open[l]) begin
`ifdef GATE_HOLD_EN
          m_hold[l] = HOLD;
`else
          m_open[l] = 1'b0;
`endif
        end else if (m_hold[l] > 0) begin
          m_hold[l]--;
          if (m_hold[l] == 0) m_open[l] = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cnt",        bus.count,           m_cnt);
    check("free",       bus.free_slots,      CAP - m_cnt);
    check("full",       bus.next_full,       (m_cnt == CAP));
    check("entry_gate", bus.entry_gate_open, m_open[0]);
    check("exit_gate",  bus.exit_gate_open,  m_open[1]);
    check("reject",     bus.entry_reject,    m_rej);
    check("error",      bus.exit_error,      m_err);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic car(input int lane);
    if (lane == 0) bus.entry_sensor = 1'b1; else bus.exit_sensor = 1'b1;
    cycles(8);
    if (lane == 0) bus.entry_sensor = 1'b0; else bus.exit_sensor = 1'b0;
    cycles(20);
  endtask

  initial begin
    bus.entry_sensor = 1'b0;
    bus.exit_sensor  = 1'b0;
    cycles(3);
    check("rst_count", bus.count, 0);
    check("rst_free",  bus.free_slots, 3);
    check("rst_full",  bus.next_full, 0);
    check("rst_gates", {bus.entry_gate_open, bus.exit_gate_open}, 0);
    rst_n = 1'b1;
    cycles(2);

    // First entry: event lands 2+DEB clocks after the raw edge.
    bus.entry_sensor = 1'b1;
    cycles(6);
    check("t2_pre_event", bus.count, 0);
    cycles(1);
    check("t2_count", bus.count, 1);
    check("t2_free",  bus.free_slots, 2);
    check("t2_gate",  bus.entry_gate_open, 1);
    cycles(3);
    bus.entry_sensor = 1'b0;
    cycles(6);
    check("t6_gate_pl", bus.entry_gate_open, 1);
    cycles(1);
`ifdef GATE_HOLD_EN
    check("t6_gate_hold", bus.entry_gate_open, 1);
    cycles(7);
    check("t6_gate_hold_end", bus.entry_gate_open, 1);
    cycles(1);
    check("t6_gate_closed", bus.entry_gate_open, 0);
`else
    check("t6_gate_closed", bus.entry_gate_open, 0);
    cycles(8);
`endif

    // Short glitch never survives debounce.
    bus.entry_sensor = 1'b1;
    cycles(2);
    bus.entry_sensor = 1'b0;
    cycles(12);
    check("t2_glitch_count", bus.count, 1);
    check("t2_glitch_gate",  bus.entry_gate_open, 0);

    car(0); car(0);
    check("t3_count", bus.count, 3);
    check("t3_full",  bus.next_full, 1);
    check("t3_free",  bus.free_slots, 0);
    bus.entry_sensor = 1'b1;
    cycles(7);
    check("t3_reject", bus.entry_reject, 1);
    check("t3_count_sat", bus.count, 3);
    check("t3_gate_shut", bus.entry_gate_open, 0);
    cycles(1);
    check("t3_reject_pulse", bus.entry_reject, 0);
    bus.entry_sensor = 1'b0;
    cycles(20);

    bus.exit_sensor = 1'b1;
    cycles(7);
    check("t4_exit_count", bus.count, 2);
    check("t4_exit_full",  bus.next_full, 0);
    check("t4_exit_gate",  bus.exit_gate_open, 1);
    bus.exit_sensor = 1'b0;
    cycles(20);
    car(1); car(1);
    check("t4_empty", bus.count, 0);
    bus.exit_sensor = 1'b1;
    cycles(7);
    check("t4_error", bus.exit_error, 1);
    check("t4_count0", bus.count, 0);
    check("t4_gate_shut", bus.exit_gate_open, 0);
    cycles(1);
    check("t4_error_pulse", bus.exit_error, 0);
    bus.exit_sensor = 1'b0;
    cycles(20);

    car(0); car(0); car(0);
    bus.entry_sensor = 1'b1;
    bus.exit_sensor  = 1'b1;
    cycles(7);
    check("t5_count", bus.count, 3);
    check("t5_gates", {bus.entry_gate_open, bus.exit_gate_open}, 3);
    check("t5_no_reject", bus.entry_reject, 0);
    check("t5_no_error",  bus.exit_error, 0);
    bus.entry_sensor = 1'b0;
    bus.exit_sensor  = 1'b0;
    cycles(20);

    // Reset with count=2 and the entry gate open, sensor still held.
    car(1); car(1);
    bus.entry_sensor = 1'b1;
    cycles(8);
    check("t1_pre_count", bus.count, 2);
    check("t1_pre_gate",  bus.entry_gate_open, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_count", bus.count, 0);
    check("t1_free",  bus.free_slots, 3);
    check("t1_full",  bus.next_full, 0);
    check("t1_gates", {bus.entry_gate_open, bus.exit_gate_open}, 0);
    cycles(2);
    bus.entry_sensor = 1'b0;
    #2 rst_n = 1'b1;

    // Random traffic, occasional simultaneous changes and rare resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        logic v;
        v = 1'($urandom_range(0, 1));
        bus.entry_sensor = v;
        bus.exit_sensor  = v;
      end else begin
        if ($urandom_range(0, 5) == 0) bus.entry_sensor = ~bus.entry_sensor;
        if ($urandom_range(0, 5) == 0) bus.exit_sensor  = ~bus.exit_sensor;
      end
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    bus.entry_sensor = 1'b0;
    bus.exit_sensor  = 1'b0;
    cycles(30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
